// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that collects key presses into a small event FIFO.
// The level key (top bit) is edge-detected here; a press merged into a still-pending one sets a sticky overflow flag.
module key_event_arbiter #(
  parameter int NKEYS = 5,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_in,
  output logic [2:0]       evt_code,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [PTR_W:0]   evt_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  // Handshake: the head entry transfers on a rising clk edge where evt_valid && evt_ready;
  // evt_valid/evt_code hold steady until then, and evt_ready is ignored while empty.

  logic             r_key_q;
  logic [NKEYS-1:0] r_pending;
  logic [2:0]       r_last_grant;
  logic [2:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic [NKEYS-1:0] w_press;
  logic [NKEYS-1:0] w_grant;
  logic [2:0]       w_grant_idx;
  logic             w_grant_vld;
  logic             w_pop;
  logic             w_can_push;
  logic             w_merge;

  assign evt_valid  = (r_count != '0);
  assign evt_code   = evt_valid ? r_mem[r_rd_ptr] : 3'd0;
  assign evt_count  = r_count;
  assign overflow   = r_overflow;
  assign w_pop      = evt_valid & evt_ready;
  assign w_can_push = (r_count < (PTR_W+1)'(DEPTH)) | w_pop;
  assign w_merge    = |(w_press & r_pending & ~w_grant);

  always_comb begin
    w_press            = key_in;
    w_press[NKEYS-1]   = key_in[NKEYS-1] & ~r_key_q;
  end

  // Distance 0 is the key just after last_grant; the smallest distance among pending keys wins.
  always_comb begin
    int best_d;
    int d;
    best_d      = NKEYS;
    d           = 0;
    w_grant_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      d = i - int'(r_last_grant) - 1;
      if (d < 0) d = d + NKEYS;
      if (r_pending[i] && (d < best_d)) begin
        best_d      = d;
        w_grant_idx = 3'(i);
      end
    end
    w_grant_vld = w_can_push && (best_d < NKEYS);
    w_grant     = '0;
    for (int i = 0; i < NKEYS; i++) begin
      w_grant[i] = w_grant_vld && (w_grant_idx == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_q      <= 1'b0;
      r_pending    <= '0;
      r_last_grant <= 3'(NKEYS - 1);
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
    end else begin
      r_key_q   <= key_in[NKEYS-1];
      r_pending <= w_press | (r_pending & ~w_grant);
      if (w_grant_vld) begin
        r_last_grant     <= w_grant_idx;
        r_mem[r_wr_ptr]  <= w_grant_idx;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_grant_vld, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_merge)      r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios then random traffic, all checked each cycle
// against a queue-based reference model.
module tb_key_event_arbiter;

  localparam int NKEYS = 5;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NKEYS-1:0] key_in;
  logic [2:0]       evt_code;
  logic             evt_valid;
  logic             evt_ready;
  logic [PTR_W:0]   evt_count;
  logic             overflow;
  logic             clr_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [NKEYS-1:0] m_pend;
  logic [2:0]       exp_q[$];
  int               m_last;
  logic             m_ovf;
  logic             m_kq;

  logic [2:0]       pop_log[$];

  key_event_arbiter #(.NKEYS(NKEYS), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_update();
    int               grant;
    int               idx;
    logic             pop;
    logic             can_push;
    logic             set_ovf;
    logic [NKEYS-1:0] press;
    if (rst) begin
      m_pend = '0;
      exp_q.delete();
      m_last = NKEYS - 1;
      m_ovf  = 1'b0;
      m_kq   = 1'b0;
      return;
    end
    press            = key_in;
    press[NKEYS-1]   = key_in[NKEYS-1] & ~m_kq;
    pop              = (exp_q.size() > 0) && evt_ready;
    can_push         = (exp_q.size() < DEPTH) || pop;
    grant            = -1;
    if (can_push) begin
      for (int k = 1; k <= NKEYS; k++) begin
        idx = (m_last + k) % NKEYS;
        if (grant < 0 && m_pend[idx]) grant = idx;
      end
    end
    set_ovf = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (press[i] && m_pend[i] && i != grant) set_ovf = 1'b1;
      m_pend[i] = press[i] | (m_pend[i] && i != grant);
    end
    if (pop) void'(exp_q.pop_front());
    if (grant >= 0) begin
      exp_q.push_back(3'(grant));
      m_last = grant;
    end
    if (set_ovf)      m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_kq = key_in[NKEYS-1];
  endtask

  // One clock: log any transfer, advance the model on the edge, compare 1 time unit later.
  task automatic step();
    if (evt_valid && evt_ready && !rst) pop_log.push_back(evt_code);
    @(posedge clk);
    model_update();
    #1;
    check("valid", 32'(evt_valid), 32'(exp_q.size() > 0));
    check("code", 32'(evt_code), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check("count", 32'(evt_count), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic pulse(input logic [NKEYS-1:0] keys);
    key_in = keys;
    step();
    key_in = '0;
  endtask

  function automatic int log_at(input int i);
    return (pop_log.size() > i) ? int'(pop_log[i]) : 99;
  endfunction

  initial begin
    logic [2:0] seq5[5];
    int         n1;
    rst = 1'b1; key_in = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
    m_pend = '0; m_last = NKEYS - 1; m_ovf = 1'b0; m_kq = 1'b0;
    step(); step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // single press with two-edge latency
    repeat (8) step();
    pulse(5'b00100);
    check("sp_not_yet", 32'(evt_valid), 32'd0);
    step();
    check("sp_valid", 32'(evt_valid), 32'd1);
    check("sp_code", 32'(evt_code), 32'd2);
    check("sp_count", 32'(evt_count), 32'd1);
    evt_ready = 1'b1;
    step();
    check("sp_popped", 32'(evt_valid), 32'd0);
    check("sp_count0", 32'(evt_count), 32'd0);

    // simultaneous presses from reset priority
    rst = 1'b1; step(); rst = 1'b0;
    pulse(5'b01011);
    step(); check("sim_0", 32'(evt_code), 32'd0);
    step(); check("sim_1", 32'(evt_code), 32'd1);
    step(); check("sim_3", 32'(evt_code), 32'd3);
    step(); check("sim_empty", 32'(evt_valid), 32'd0);
    // last grant is 3: the search starts at 4 and wraps to 0 before reaching 3
    pulse(5'b01001);
    step(); check("rot_first", 32'(evt_code), 32'd0);
    step(); check("rot_second", 32'(evt_code), 32'd3);
    step();

    // level key held high
    pop_log.delete();
    key_in[4] = 1'b1;
    repeat (50) step();
    key_in = '0;
    repeat (3) step();
    check("lvl_events", 32'(pop_log.size()), 32'd1);
    check("lvl_code", 32'(log_at(0)), 32'd4);
    pop_log.delete();
    key_in[4] = 1'b1;
    repeat (3) step();
    key_in = '0;
    repeat (4) step();
    check("lvl_repress", 32'(pop_log.size()), 32'd1);
    check("lvl_ovf", 32'(overflow), 32'd0);

    // backpressure until full, then drain
    evt_ready = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      pulse(5'(1 << k));
      step();
    end
    repeat (3) step();
    check("bp_full", 32'(evt_count), 32'd4);
    check("bp_head", 32'(evt_code), 32'd0);
    check("bp_ovf", 32'(overflow), 32'd0);
    pop_log.delete();
    evt_ready = 1'b1;
    repeat (8) step();
    seq5 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    check("bp_n", 32'(pop_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("bp_order", 32'(log_at(i)), 32'(seq5[i]));
    check("bp_empty", 32'(evt_count), 32'd0);

    // overflow by merged press while full
    evt_ready = 1'b0;
    pulse(5'b00001); step();
    pulse(5'b00100); step();
    pulse(5'b01000); step();
    pulse(5'b10000); step();
    pulse(5'b00010);
    repeat (5) step();
    check("ovf_before", 32'(overflow), 32'd0);
    pulse(5'b00010);
    check("ovf_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b1; pulse(5'b00010); clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    pop_log.delete();
    evt_ready = 1'b1;
    repeat (10) step();
    n1 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 3'd1) n1++;
    check("ovf_one_evt", 32'(n1), 32'd1);
    check("ovf_drained", 32'(pop_log.size()), 32'd5);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    // reset with queued and pending events
    evt_ready = 1'b0;
    pulse(5'b00001); step();
    pulse(5'b00010); step();
    pulse(5'b00100); step();
    pulse(5'b11000);
    check("mid_count", 32'(evt_count), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_valid", 32'(evt_valid), 32'd0);
    check("mid_count0", 32'(evt_count), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    pulse(5'b10001);
    step();
    check("mid_first", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    step();
    check("mid_second", 32'(evt_code), 32'd4);
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NKEYS - 1; i++) key_in[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) key_in[NKEYS-1] = ~key_in[NKEYS-1];
      evt_ready = (c % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; key_in = '0; clr_ovf = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
